// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core with on-the-fly key expansion.
// UNROLL rounds (1, 2 or 5) are evaluated per clock. The final round skips
// MixColumns inside the same round datapath.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready plaintext+key handshake (accepted only in IDLE)
//   plaintext, key    128-bit, bits [127:120] are byte 0
//   out_valid/out_ready ciphertext handshake (held in DONE)
//   ciphertext        registered result, kept after the handshake
//   busy              high while a block is in flight (RUN or DONE)

// One S-box byte: field inverse (a^254) followed by the affine map.
module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] inv;

   // Square-and-multiply over exponent 8'b1111_1110; zero maps to zero.
   always_comb begin
      inv = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         inv = gmul(inv, inv);
         if (i != 0) inv = gmul(inv, a_i);
      end
   end

   assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module sub_bytes (
   input  logic [127:0] d_i,
   output logic [127:0] d_o
);
   for (genvar b = 0; b < 16; b++) begin : g_sb
      aes_sbox u_sbox (.a_i(d_i[127-8*b -: 8]), .s_o(d_o[127-8*b -: 8]));
   end
endmodule

// Byte r+4c (row r, column c) takes row r's byte from column (c+r) mod 4.
module shift_row (
   input  logic [127:0] d_i,
   output logic [127:0] d_o
);
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign d_o[127-8*(4*c+r) -: 8] = d_i[127-8*(4*((c+r)%4)+r) -: 8];
      end
   end
endmodule

module mix_columns (
   input  logic [127:0] d_i,
   output logic [127:0] d_o
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = d_i[127-32*c -: 8];
      assign a1 = d_i[119-32*c -: 8];
      assign a2 = d_i[111-32*c -: 8];
      assign a3 = d_i[103-32*c -: 8];
      assign d_o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                    a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                    a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                    xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   end
endmodule

// Next round key from the previous one; rc_i is the 1-based round index.
module key_gen (
   input  logic [3:0]   rc_i,
   input  logic [127:0] key_i,
   output logic [127:0] key_o
);
   logic [31:0] rot, sw, w0, w1, w2, w3;
   logic [7:0]  rcon;

   assign rot = {key_i[23:0], key_i[31:24]};
   for (genvar g = 0; g < 4; g++) begin : g_sw
      aes_sbox u_sbox (.a_i(rot[31-8*g -: 8]), .s_o(sw[31-8*g -: 8]));
   end

   always_comb begin
      rcon = 8'h00;
      case (rc_i)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign w0    = key_i[127:96] ^ sw ^ {rcon, 24'h0};
   assign w1    = key_i[95:64]  ^ w0;
   assign w2    = key_i[63:32]  ^ w1;
   assign w3    = key_i[31:0]   ^ w2;
   assign key_o = {w0, w1, w2, w3};
endmodule

module aes128_iter_core #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy
);
   localparam int NCYC = 10 / UNROLL;

   if ((UNROLL != 1 && UNROLL != 2 && UNROLL != 5) || NCYC * UNROLL != 10) begin : g_bad_unroll
      $error("aes128_iter_core: UNROLL must be 1, 2 or 5");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] st_q, st_d, key_q, key_d, ct_q, ct_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [4:0]   last_rnd;

   // Round chain: stage u computes round rnd_q+u from the previous stage.
   for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
      logic [3:0]   rc;
      logic [127:0] st_in, rk_in, sb, sr, mc, rk_out, st_out;
      if (u == 0) begin : g_first
         assign st_in = st_q;
         assign rk_in = key_q;
      end else begin : g_next
         assign st_in = g_rnd[u-1].st_out;
         assign rk_in = g_rnd[u-1].rk_out;
      end
      assign rc = rnd_q + 4'(u);
      sub_bytes   u_sb (.d_i(st_in), .d_o(sb));
      shift_row   u_sr (.d_i(sb),    .d_o(sr));
      mix_columns u_mc (.d_i(sr),    .d_o(mc));
      key_gen     u_kg (.rc_i(rc), .key_i(rk_in), .key_o(rk_out));
      assign st_out = ((rc == 4'd10) ? sr : mc) ^ rk_out;
   end

   assign last_rnd = {1'b0, rnd_q} + 5'(UNROLL - 1);

   always_comb begin
      fsm_d = fsm_q;
      st_d  = st_q;
      key_d = key_q;
      rnd_d = rnd_q;
      ct_d  = ct_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid) begin
               st_d  = plaintext ^ key;
               key_d = key;
               rnd_d = 4'd1;
               fsm_d = S_RUN;
            end
         end
         S_RUN: begin
            // A round index past 10 can only come from a corrupted register.
            if (rnd_q > 4'd10 || last_rnd > 5'd10) begin
               rnd_d = '0;
               fsm_d = S_IDLE;
            end else begin
               st_d  = g_rnd[UNROLL-1].st_out;
               key_d = g_rnd[UNROLL-1].rk_out;
               rnd_d = rnd_q + 4'(UNROLL);
               if (last_rnd == 5'd10) begin
                  ct_d  = g_rnd[UNROLL-1].st_out;
                  rnd_d = '0;
                  fsm_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) fsm_d = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q <= S_IDLE;
         st_q  <= '0;
         key_q <= '0;
         rnd_q <= '0;
         ct_q  <= '0;
      end else begin
         fsm_q <= fsm_d;
         st_q  <= st_d;
         key_q <= key_d;
         rnd_q <= rnd_d;
         ct_q  <= ct_d;
      end
   end

   assign in_ready   = (fsm_q == S_IDLE);
   assign out_valid  = (fsm_q == S_DONE);
   assign busy       = (fsm_q == S_RUN) || (fsm_q == S_DONE);
   assign ciphertext = ct_q;
endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: three instances (UNROLL 1, 2, 5) share the
// stimulus; a block-level AES model with a per-instance latency tracker is
// compared against every instance each cycle, plus literal FIPS-197 checks.
module tb_aes128_iter_core;
   localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam int NC [3] = '{10, 5, 2};

   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [127:0] plaintext = '0, key = '0;
   logic [2:0] ir, ov, bz;
   logic [2:0][127:0] ct;
   int  chks = 0, errs = 0;
   bit  chk_en = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes128_iter_core #(.UNROLL(g == 0 ? 1 : (g == 1 ? 2 : 5))) u_dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]),
         .plaintext(plaintext), .key(key), .out_valid(ov[g]),
         .out_ready(out_ready), .ciphertext(ct[g]), .busy(bz[g]));
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBOX[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Straight FIPS-197 encryption on byte arrays (column-major state).
   function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] w [16];
      logic [7:0] tmp [4];
      logic [7:0] rcon, a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         w[i] = k[127-8*i -: 8];
         s[i] = p[127-8*i -: 8] ^ w[i];
      end
      rcon = 8'h01;
      for (int rd = 1; rd <= 10; rd++) begin
         tmp[0] = sb(w[13]) ^ rcon; tmp[1] = sb(w[14]);
         tmp[2] = sb(w[15]);        tmp[3] = sb(w[12]);
         for (int j = 0; j < 4; j++)  w[j] = w[j] ^ tmp[j];
         for (int j = 4; j < 16; j++) w[j] = w[j] ^ w[j-4];
         rcon = xt(rcon);
         for (int j = 0; j < 16; j++) s[j] = sb(s[j]);
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rd != 10) begin
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[j];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   // Transaction model: phase 0 idle, 1 computing (NC edges), 2 holding result.
   int          m_ph  [3];
   int          m_cnt [3];
   logic [127:0] m_ct [3];
   logic [127:0] m_res[3];

   initial for (int i = 0; i < 3; i++) begin m_ph[i] = 0; m_cnt[i] = 0; end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_ph[i] <= 0; m_ct[i] <= '0; m_cnt[i] <= 0;
         end else if (m_ph[i] == 0) begin
            if (in_valid) begin
               m_ph[i] <= 1; m_cnt[i] <= NC[i] - 1; m_res[i] <= aes_ref(plaintext, key);
            end
         end else if (m_ph[i] == 1) begin
            if (m_cnt[i] == 0) begin m_ph[i] <= 2; m_ct[i] <= m_res[i]; end
            else m_cnt[i] <= m_cnt[i] - 1;
         end else if (out_ready) begin
            m_ph[i] <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("in_ready[u%0d]", i), ir[i], m_ph[i] == 0);
            chk($sformatf("out_valid[u%0d]", i), ov[i], m_ph[i] == 2);
            chk($sformatf("busy[u%0d]", i), bz[i], m_ph[i] != 0);
            chk($sformatf("ciphertext[u%0d]", i), ct[i], m_ct[i]);
         end
      end
   end

   task automatic run_block(input logic [127:0] p, input logic [127:0] k,
                            input logic [127:0] exp, input bit scramble);
      int lat [3];
      int n;
      @(negedge clk);
      plaintext = p; key = k; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (scramble) begin plaintext = '1; key = '1; end
      for (int i = 0; i < 3; i++) lat[i] = -1;
      n = 0;
      while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0) && n < 40) begin
         @(posedge clk); n++; #1;
         for (int i = 0; i < 3; i++)
            if (lat[i] < 0 && ov[i]) begin
               lat[i] = n;
               chk($sformatf("blk_ct[u%0d]", i), ct[i], exp);
            end
      end
      for (int i = 0; i < 3; i++) chk($sformatf("blk_latency[u%0d]", i), lat[i], NC[i]);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int n;
      logic [24:0] pat;
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [24:0] pat;
      chk("model_fips_b", aes_ref(PB, KB), CB);
      chk("model_fips_c1", aes_ref(PC, KC), CC);

      // Reset
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_in_ready[u%0d]", i), ir[i], 1'b1);
         chk($sformatf("rst_out_valid[u%0d]", i), ov[i], 1'b0);
         chk($sformatf("rst_busy[u%0d]", i), bz[i], 1'b0);
         chk($sformatf("rst_ct[u%0d]", i), ct[i], 128'h0);
      end
      rst = 1'b0;
      chk_en = 1'b1;

      run_block(PB, KB, CB, 1'b0);
      run_block(PC, KC, CC, 1'b0);

      // Backpressure with in_valid held high
      @(negedge clk);
      plaintext = PB; key = KB; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!ov[0] && n < 40) begin @(posedge clk); n++; #1; end
      chk("bp_out_valid_seen", ov[0], 1'b1);
      repeat (20) begin
         @(posedge clk); #1;
         chk("bp_ct_stable", ct[0], CB);
         chk("bp_in_ready_low", ir[0], 1'b0);
         chk("bp_out_valid_held", ov[0], 1'b1);
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_hs_out_valid", ov[0], 1'b0);
      chk("bp_hs_in_ready", ir[0], 1'b1);
      chk("bp_hs_ct_kept", ct[0], CB);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);

      // Back-to-back: B then C.1 with in_valid held
      @(negedge clk);
      plaintext = PB; key = KB; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      plaintext = PC; key = KC;
      pat = '0;
      for (int e = 1; e <= 24; e++) begin
         @(posedge clk); #1;
         pat[e] = ov[0];
         if (e == 10) chk("b2b_ct_first", ct[0], CB);
         if (e == 22) chk("b2b_ct_second", ct[0], CC);
         if (e == 11) chk("b2b_ready_after_hs", ir[0], 1'b1);
         if (e == 12) begin
            chk("b2b_second_accept", bz[0], 1'b1);
            in_valid = 1'b0;
         end
      end
      chk("b2b_out_valid_pattern", pat, 25'h0400400);
      repeat (6) @(posedge clk);

      // Reset during RUN cycle 4
      @(negedge clk);
      plaintext = PB; key = KB; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int e = 1; e <= 14; e++) begin
         rst = (e == 4);
         @(posedge clk); #1;
         chk("rstmid_no_out_valid", ov[0], 1'b0);
         if (e == 4) begin
            chk("rstmid_in_ready", ir[0], 1'b1);
            chk("rstmid_busy", bz[0], 1'b0);
            chk("rstmid_ct", ct[0], 128'h0);
         end
      end
      rst = 1'b0;
      run_block(PB, KB, CB, 1'b0);

      // Inputs scrambled to all-ones during RUN
      run_block(PC, KC, CC, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", chks, errs);
      $finish;
   end
endmodule
